// File: rtl/hash_round_unwinder.sv
`default_nettype none
// ============================================================================
// Module   : hash_round_unwinder (+ aes_inv_sbox)
// Brief    : Runs the byte-wise hash main round backwards. It loads a digest,
//            accepts message bytes last-first on a valid/ready stream and
//            undoes one round per byte. It then reports whether the recovered
//            chaining state equals the IV.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes_inv_sbox: standard AES inverse S-box, computed arithmetically.
// The inverse affine map is applied first, then the GF(2^8) inverse
// (x^254, with 0 -> 0).
// ----------------------------------------------------------------------------
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 using a fixed square/multiply chain
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gf_mul(gf_mul(x, x), x);   // x^3
    t = gf_mul(gf_mul(t, t), x);   // x^7
    t = gf_mul(gf_mul(t, t), x);   // x^15
    t = gf_mul(gf_mul(t, t), x);   // x^31
    t = gf_mul(gf_mul(t, t), x);   // x^63
    t = gf_mul(gf_mul(t, t), x);   // x^127
    return gf_mul(t, t);           // x^254
  endfunction

  logic [7:0] w_aff;

  // Inverse affine transform: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  assign w_aff = {in_byte[6:0], in_byte[7]}
               ^ {in_byte[4:0], in_byte[7:5]}
               ^ {in_byte[1:0], in_byte[7:2]}
               ^ 8'h05;

  assign out_byte = gf_inv(w_aff);

endmodule

// ----------------------------------------------------------------------------
// hash_round_unwinder: top level
// ----------------------------------------------------------------------------
module hash_round_unwinder #(
  parameter int          LEN_W = 16,
  parameter logic [63:0] IV    = 64'h0123456789ABCDEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0][7:0]  digest_in,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             m_valid,
  input  logic [7:0]       m_data,
  output logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [7:0][7:0]  state_out
);

  localparam logic [1:0]       c_ST_IDLE = 2'd0;
  localparam logic [1:0]       c_ST_RUN  = 2'd1;
  localparam logic [1:0]       c_ST_FIN  = 2'd2;
  localparam logic [LEN_W-1:0] c_LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] c_LEN_ZERO = '0;

  logic [1:0]       fsm_q,   fsm_d;
  logic [7:0][7:0]  h_q,     h_d;
  logic [LEN_W-1:0] rem_q,   rem_d;
  logic             match_q, match_d;
  logic             done_q,  done_d;

  logic [7:0][7:0]  w_sinv;
  logic [7:0][7:0]  w_inv_state;
  logic             w_accept;

  // One inverse-round lane per byte: h[(i+1)%8] = rotr8(Sinv(h_out[i]), i) ^ M
  generate
    for (genvar i = 0; i < 8; i++) begin : g_lane
      logic [15:0] w_dbl;

      aes_inv_sbox u_inv_sbox (
        .in_byte  (h_q[i]),
        .out_byte (w_sinv[i])
      );

      // Doubled byte so an i-bit right rotate is a plain constant slice
      assign w_dbl = {w_sinv[i], w_sinv[i]};
      assign w_inv_state[(i + 1) % 8] = w_dbl[i + 7 : i] ^ m_data;
    end
  endgenerate

  assign w_accept = (fsm_q == c_ST_RUN) && m_valid;

  // State register: all flops, async active-low clear discards any partial unwind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= c_ST_IDLE;
      h_q     <= '0;
      rem_q   <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      h_q     <= h_d;
      rem_q   <= rem_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start leaves IDLE, last accepted byte leaves RUN, FIN lasts one cycle
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      c_ST_IDLE: begin
        if (start) fsm_d = (msg_len != c_LEN_ZERO) ? c_ST_RUN : c_ST_FIN;
      end
      c_ST_RUN: begin
        if (w_accept && (rem_q == c_LEN_ONE)) fsm_d = c_ST_FIN;
      end
      c_ST_FIN: fsm_d = c_ST_IDLE;
      default:  fsm_d = c_ST_IDLE;
    endcase
  end

  // Datapath updates: load on start, unwind on accepted byte, compare in FIN
  always_comb begin
    h_d     = h_q;
    rem_d   = rem_q;
    match_d = match_q;
    done_d  = 1'b0;
    case (fsm_q)
      c_ST_IDLE: begin
        if (start) begin
          h_d     = digest_in;
          rem_d   = msg_len;
          match_d = 1'b0;
        end
      end
      c_ST_RUN: begin
        if (w_accept) begin
          h_d   = w_inv_state;
          rem_d = rem_q - c_LEN_ONE;
        end
      end
      c_ST_FIN: begin
        match_d = (h_q == IV);
        done_d  = 1'b1;
      end
      default: begin
        h_d = h_q;
      end
    endcase
  end

  // Output decode from the current state and result flops
  always_comb begin
    m_ready   = (fsm_q == c_ST_RUN);
    busy      = (fsm_q == c_ST_RUN) || (fsm_q == c_ST_FIN);
    done      = done_q;
    match     = match_q;
    state_out = h_q;
  end

endmodule
`default_nettype wire

// File: doc/hash_round_unwinder.md
Name: hash_round_unwinder

Overview:
- Sequential inverse of the byte-wise hash main round.
- Loads a 64-bit digest, then consumes message bytes in reverse order (last byte first) over a valid/ready stream, undoing one round per accepted byte.
- After the programmed length, compares the recovered chaining state with the IV and reports match/mismatch.
- Used in the verification/debug path to check digests against a known message without re-running the forward chain.

Parameters:
- LEN_W, 16, width of the message-length counter (max length 2^LEN_W-1 bytes).
- IV, 64'h0123456789ABCDEF, expected initial hash state; byte lane i = IV[8i+7:8i].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin unwind; sampled only in IDLE.
- digest_in  in  [7:0][7:0]  final hash state; lane i = h[i]; latched on accepted start.
- msg_len  in  LEN_W  number of bytes to unwind; latched on accepted start.
- m_valid  in  1  message byte valid.
- m_data  in  8  message byte, supplied in reverse message order.
- m_ready  out  1  block accepts m_data this cycle.
- busy  out  1  high in RUN and FIN.
- done  out  1  one-cycle pulse: result valid.
- match  out  1  recovered state == IV; held until next accepted start.
- state_out  out  [7:0][7:0]  current recovered state register.

Behaviour:
- Forward round (normative definition): h_out[i] = S(rotl8(h[(i+1)%8] ^ M, i)), i = 0..7, S = AES S-box.
- Inverse round, applied per accepted byte M: h[(i+1)%8] = rotr8(Sinv(h_out[i]), i) ^ M.
  - Eight aes_inv_sbox instances (8-bit combinational, standard AES inverse S-box).
  - Rotation is a true 8-bit rotate; no truncation of intermediate values.
- Reset (async, rst_n=0):
  - FSM to IDLE; state_out=0, remaining=0.
  - m_ready=0, busy=0, done=0, match=0.
  - Applies mid-operation; a partial unwind is discarded.
- FSM states IDLE, RUN, FIN:
  - IDLE: m_ready=0. On start=1:
    - state <= digest_in, remaining <= msg_len, match <= 0.
    - Next state is RUN if msg_len != 0, else FIN.
  - RUN: m_ready=1. On m_valid&&m_ready:
    - state <= inverse_round(state, m_data), remaining <= remaining-1.
    - If remaining==1, go to FIN.
    - m_valid=0 stalls with no state change; no timeout.
  - FIN: one cycle, m_ready=0. On exit:
    - match <= (state == IV), done <= 1 for exactly one cycle.
    - Return to IDLE.
- Latency: start accepted on edge E, N bytes with no stall accepted on edges E+1..E+N, FIN occupies the cycle after E+N, done/match are visible after edge E+N+1. Each stall cycle adds one cycle.
- Throughput: one byte per cycle.
- start while busy is ignored; no effect on state, remaining or outputs.
- m_valid outside RUN is ignored (m_ready=0).
- New start is accepted in the same cycle done is high (FSM is already in IDLE).
- msg_len=0: no bytes consumed; match = (digest_in == IV).
- state_out updates only on accepted bytes and on start; it is stable during stalls and FIN.

Test Plan:
- Single byte, match: IV=all 0xA5, digest_in=all 0x63, msg_len=1, m_data=0xA5 -> state_out all 0xA5; done after 2 cycles post-start; match=1.
- Lane/rotation check: digest_in=all 0xFB, msg_len=1, m_data=0x00 -> state_out lanes 0..7 = C6,63,B1,D8,6C,36,1B,8D; match=0 with default IV.
- Stalls: repeat the first test with m_valid low for 3 cycles before the byte -> identical result; done 3 cycles later; state_out unchanged during stall.
- Zero length: msg_len=0, digest_in=IV -> no m_ready assertion; done one cycle after FIN; match=1. Repeat with digest_in=IV^1 -> match=0.
- Reset mid-op: msg_len=4, 2 bytes accepted, assert rst_n=0 -> state_out=0, busy=0, match=0, m_ready=0 immediately. New start after release runs normally.
- Ignored start plus round-trip: pulse start during RUN -> no restart. Random IV/message of 16 bytes, forward chain computed in bench, digest unwound -> match=1. Flip one message byte -> match=0.
